channel_sample_scheduler: RTL and testbench



---
 rtl/channel_sample_scheduler_if.sv | 35 +++
 rtl/channel_sample_scheduler.sv | 154 +++++++++++++++
 tb/tb_channel_sample_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_sample_scheduler_if.sv
// Control/config and shift-strobe bundle between the top level and the sample scheduler.
// The master side drives start/stop/config; the slave side is the scheduler itself.
interface channel_sample_scheduler_if #(
  parameter int NUM_CHANNELS = 7,
  parameter int DEPTH        = 10,
  parameter int DIV_WIDTH    = 16,
  parameter int CH_W         = $clog2(NUM_CHANNELS),
  parameter int CNT_W        = $clog2(DEPTH + 1)
);
  // start/stop are single-cycle pulses sampled on the rising clock edge; there is
  // no valid/ready pairing: a pulse the scheduler cannot use is dropped, and a
  // rejected start (zero mask) is reported by a one-cycle cfg_err pulse.
  logic                    start;
  logic                    stop;
  logic [NUM_CHANNELS-1:0] chan_mask;
  logic [DIV_WIDTH-1:0]    sample_div;
  logic [NUM_CHANNELS-1:0] shift_en;
  logic [CH_W-1:0]         cur_chan;
  logic [CNT_W-1:0]        sample_cnt;
  logic                    busy;
  logic                    frame_done;
  logic                    full;
  logic                    cfg_err;
  logic [1:0]              dbg_state;

  modport master (
    output start, stop, chan_mask, sample_div,
    input  shift_en, cur_chan, sample_cnt, busy, frame_done, full, cfg_err, dbg_state
  );

  modport slave (
    input  start, stop, chan_mask, sample_div,
    output shift_en, cur_chan, sample_cnt, busy, frame_done, full, cfg_err, dbg_state
  );
endinterface

// File: rtl/channel_sample_scheduler.sv
// Sweep sequencer for the channel sample buffers: waits sample_div+1 cycles, then
// strobes each enabled channel once in ascending order, until DEPTH sweeps are done.
module channel_sample_scheduler #(
  parameter int NUM_CHANNELS = 7,
  parameter int DEPTH        = 10,
  parameter int DIV_WIDTH    = 16,
  parameter int CH_W         = $clog2(NUM_CHANNELS),
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  channel_sample_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [NUM_CHANNELS-1:0] mask_q, mask_n;
  logic [DIV_WIDTH-1:0]    div_cnt, div_n;
  logic [CH_W-1:0]         ch_ptr, ptr_n;
  logic                    stop_pend, stop_n;
  logic [CNT_W-1:0]        sample_cnt, cnt_n;
  logic                    frame_done_q, frame_done_n;
  logic                    cfg_err_q, cfg_err_n;

  logic [CH_W-1:0]         first_idx;
  logic [CH_W-1:0]         next_idx;
  logic                    next_found;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    start_ok;
  logic                    stop_any;

  // Lowest enabled channel, and lowest enabled channel above ch_ptr.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_idx = CH_W'(i);
        if (CH_W'(i) > ch_ptr) begin
          next_idx   = CH_W'(i);
          next_found = 1'b1;
        end
      end
    end
  end

  assign cnt_inc  = (sample_cnt == CNT_W'(DEPTH)) ? sample_cnt : sample_cnt + CNT_W'(1);
  assign start_ok = bus.start && (bus.chan_mask != '0);
  assign stop_any = stop_pend || bus.stop;

  always_comb begin
    state_n      = state;
    mask_n       = mask_q;
    div_n        = div_cnt;
    ptr_n        = ch_ptr;
    stop_n       = stop_pend;
    cnt_n        = sample_cnt;
    frame_done_n = 1'b0;
    cfg_err_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          mask_n  = bus.chan_mask;
          div_n   = bus.sample_div;
          cnt_n   = '0;
          state_n = S_WAIT;
        end else if (bus.start) begin
          cfg_err_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.stop) begin
          state_n = S_IDLE;
        end else if (div_cnt == '0) begin
          ptr_n   = first_idx;
          state_n = S_SWEEP;
        end else begin
          div_n = div_cnt - DIV_WIDTH'(1);
        end
      end
      S_SWEEP: begin
        stop_n = stop_any;
        if (next_found) begin
          ptr_n = next_idx;
        end else begin
          // The last strobe of a sweep: completing the frame outranks a pending stop.
          cnt_n  = cnt_inc;
          stop_n = 1'b0;
          if (cnt_inc == CNT_W'(DEPTH)) begin
            state_n      = S_DONE;
            frame_done_n = 1'b1;
          end else if (stop_any) begin
            state_n = S_IDLE;
          end else begin
            div_n   = bus.sample_div;
            state_n = S_WAIT;
          end
        end
      end
      S_DONE: begin
        if (bus.stop) begin
          state_n = S_IDLE;
        end else if (start_ok) begin
          mask_n  = bus.chan_mask;
          div_n   = bus.sample_div;
          cnt_n   = '0;
          state_n = S_WAIT;
        end else if (bus.start) begin
          cfg_err_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mask_q       <= '0;
      div_cnt      <= '0;
      ch_ptr       <= '0;
      stop_pend    <= 1'b0;
      sample_cnt   <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state        <= state_n;
      mask_q       <= mask_n;
      div_cnt      <= div_n;
      ch_ptr       <= ptr_n;
      stop_pend    <= stop_n;
      sample_cnt   <= cnt_n;
      frame_done_q <= frame_done_n;
      cfg_err_q    <= cfg_err_n;
    end
  end

  assign bus.shift_en   = (state == S_SWEEP) ? (NUM_CHANNELS'(1) << ch_ptr) : '0;
  assign bus.cur_chan   = (state == S_SWEEP) ? ch_ptr : '0;
  assign bus.sample_cnt = sample_cnt;
  assign bus.busy       = (state == S_WAIT) || (state == S_SWEEP);
  assign bus.frame_done = frame_done_q;
  assign bus.full       = (state == S_DONE);
  assign bus.cfg_err    = cfg_err_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_channel_sample_scheduler.sv
// Bench for channel_sample_scheduler: a frame-level timeline model checked every cycle,
// plus directed scenarios with literal expectations at hand-computed cycles.
module tb_channel_sample_scheduler;
  localparam int N     = 7;
  localparam int DEPTH = 10;
  localparam int DW    = 16;
  localparam int CH_W  = 3;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [N-1:0]     se;
    logic [CH_W-1:0]  cc;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             fd;
    logic             full;
  } exp_t;
  localparam int EW = $bits(exp_t);

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  channel_sample_scheduler_if #(.NUM_CHANNELS(N), .DEPTH(DEPTH), .DIV_WIDTH(DW)) bus ();

  channel_sample_scheduler #(.NUM_CHANNELS(N), .DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // scoreboard: per-cycle expected outputs of the running frame
  logic [EW-1:0]    exp_q[$];
  bit               m_live = 1'b0;
  bit               m_done = 1'b0;
  logic [CNT_W-1:0] m_cnt  = '0;
  bit               m_err  = 1'b0;

  task automatic build_frame(input logic [N-1:0] mask, input logic [DW-1:0] div);
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      for (int w = 0; w <= int'(div); w++) begin
        e = '0; e.cnt = CNT_W'(k); e.busy = 1'b1;
        exp_q.push_back(e);
      end
      for (int ch = 0; ch < N; ch++) begin
        if (mask[ch]) begin
          e = '0; e.se = N'(1) << ch; e.cc = CH_W'(ch); e.cnt = CNT_W'(k); e.busy = 1'b1;
          exp_q.push_back(e);
        end
      end
    end
    e = '0; e.cnt = CNT_W'(DEPTH); e.fd = 1'b1; e.full = 1'b1;
    exp_q.push_back(e);
    m_done = 1'b1;
    m_cnt  = CNT_W'(DEPTH);
  endtask

  always @(negedge clk) begin : model
    exp_t cur;
    exp_t act;
    exp_t nx;
    int   keep;
    cur = '0;
    if (m_live) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else begin
        cur = '0; cur.cnt = m_cnt; cur.full = m_done;
      end
      act = {bus.shift_en, bus.cur_chan, bus.sample_cnt, bus.busy, bus.frame_done, bus.full};
      check("model_outputs", 32'(act), 32'(cur));
      check("model_cfg_err", 32'(bus.cfg_err), 32'(m_err));
    end
    m_err = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_done = 1'b0;
      m_cnt  = '0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (bus.stop && cur.busy) begin
        if (cur.se == '0) begin
          exp_q.delete();
          m_done = 1'b0;
          m_cnt  = cur.cnt;
        end else if (int'(cur.cnt) != DEPTH - 1) begin
          // finish this sweep's remaining strobes, then idle with one more sweep counted
          keep = 0;
          while (keep < exp_q.size()) begin
            nx = exp_q[keep];
            if (nx.se == '0) break;
            keep++;
          end
          while (exp_q.size() > keep) void'(exp_q.pop_back());
          m_done = 1'b0;
          m_cnt  = cur.cnt + CNT_W'(1);
        end
      end else if (bus.stop && cur.full) begin
        exp_q.delete();
        m_done = 1'b0;
      end else if (bus.start && !cur.busy) begin
        if (bus.chan_mask != '0) build_frame(bus.chan_mask, bus.sample_div);
        else m_err = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [N-1:0] mask, input logic [DW-1:0] div, input logic with_stop);
    bus.chan_mask  = mask;
    bus.sample_div = div;
    bus.start      = 1'b1;
    bus.stop       = with_stop;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic run_basic(input string tag);
    pulse_start(7'b0000101, 16'd2, 1'b0);
    for (int c = 1; c <= 53; c++) begin
      if (c == 3)  check({tag, "_c3_busy"}, 32'(bus.busy), 32'd1);
      if (c == 4)  check({tag, "_c4_shift"}, 32'(bus.shift_en), 32'h01);
      if (c == 5)  check({tag, "_c5_shift"}, 32'(bus.shift_en), 32'h04);
      if (c == 9)  check({tag, "_c9_shift"}, 32'(bus.shift_en), 32'h01);
      if (c == 50) check({tag, "_c50_fd"}, 32'(bus.frame_done), 32'd0);
      if (c == 51) begin
        check({tag, "_c51_fd"}, 32'(bus.frame_done), 32'd1);
        check({tag, "_c51_cnt"}, 32'(bus.sample_cnt), 32'd10);
        check({tag, "_c51_full"}, 32'(bus.full), 32'd1);
      end
      if (c == 52) check({tag, "_c52_fd"}, 32'(bus.frame_done), 32'd0);
      tick();
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.chan_mask  = '0;
    bus.sample_div = '0;
    repeat (3) tick();
    check("reset_shift", 32'(bus.shift_en), 32'd0);
    check("reset_cnt", 32'(bus.sample_cnt), 32'd0);
    check("reset_busy_full", 32'({bus.busy, bus.full, bus.frame_done, bus.cfg_err}), 32'd0);
    reset = 1'b0;
    tick();

    // basic frame, ends in DONE
    run_basic("basic");

    // full mask, div 0, accepted straight from DONE
    pulse_start(7'h7F, 16'd0, 1'b0);
    for (int c = 1; c <= 83; c++) begin
      if (c == 1)  check("full_c1_wait", 32'({bus.busy, bus.shift_en}), 32'h080);
      if (c == 2)  check("full_c2", 32'({bus.shift_en, bus.cur_chan}), 32'({7'h01, 3'd0}));
      if (c == 5)  check("full_c5", 32'({bus.shift_en, bus.cur_chan}), 32'({7'h08, 3'd3}));
      if (c == 8)  check("full_c8", 32'({bus.shift_en, bus.cur_chan}), 32'({7'h40, 3'd6}));
      if (c == 9)  check("full_c9_shift", 32'(bus.shift_en), 32'd0);
      if (c == 81) check("full_c81_fd", 32'(bus.frame_done), 32'd1);
      tick();
    end

    // stop on the third strobe of sweep 2
    pulse_start(7'h7F, 16'd3, 1'b0);
    for (int c = 1; c <= 25; c++) begin
      if (c == 5)  check("stop_c5_shift", 32'(bus.shift_en), 32'h01);
      if (c == 18) begin
        check("stop_c18_chan", 32'(bus.cur_chan), 32'd2);
        bus.stop = 1'b1;
      end
      if (c == 22) check("stop_c22_shift", 32'(bus.shift_en), 32'h40);
      if (c == 23) begin
        check("stop_c23_cnt", 32'(bus.sample_cnt), 32'd2);
        check("stop_c23_flags", 32'({bus.busy, bus.frame_done, bus.full}), 32'd0);
      end
      tick();
      bus.stop = 1'b0;
    end

    // zero mask in IDLE
    pulse_start(7'h00, 16'd0, 1'b0);
    check("zero_c1_err", 32'(bus.cfg_err), 32'd1);
    check("zero_c1_busy", 32'({bus.busy, bus.shift_en}), 32'd0);
    tick();
    check("zero_c2_err", 32'(bus.cfg_err), 32'd0);
    tick();

    // start+stop in IDLE: start wins; mask change and busy start are ignored
    pulse_start(7'b0000011, 16'd1, 1'b1);
    for (int c = 1; c <= 44; c++) begin
      if (c == 1) check("mid_c1_busy", 32'(bus.busy), 32'd1);
      if (c == 2) bus.chan_mask = 7'h7F;
      if (c == 3) check("mid_c3_shift", 32'(bus.shift_en), 32'h01);
      if (c == 4) check("mid_c4", 32'({bus.shift_en, bus.cur_chan}), 32'({7'h02, 3'd1}));
      if (c == 6) begin
        bus.chan_mask = 7'h00;
        bus.start     = 1'b1;
      end
      if (c == 7) check("mid_c7_noerr", 32'(bus.cfg_err), 32'd0);
      if (c == 8) check("mid_c8_shift", 32'(bus.shift_en), 32'h02);
      if (c == 41) check("mid_c41_fd", 32'(bus.frame_done), 32'd1);
      tick();
      bus.start = 1'b0;
    end

    // zero mask in DONE: cfg_err, stay full
    pulse_start(7'h00, 16'd1, 1'b0);
    check("done_zero_err", 32'({bus.cfg_err, bus.full}), 32'b11);
    tick();

    // restart from DONE with only ch6, then stop during WAIT
    pulse_start(7'b1000000, 16'd1, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      if (c == 1) check("ch6_c1", 32'({bus.sample_cnt, bus.full, bus.busy}), 32'({4'd0, 1'b0, 1'b1}));
      if (c == 3) check("ch6_c3", 32'({bus.shift_en, bus.cur_chan}), 32'({7'h40, 3'd6}));
      if (c == 4) bus.stop = 1'b1;
      if (c == 5) check("ch6_c5", 32'({bus.busy, bus.sample_cnt}), 32'({1'b0, 4'd1}));
      tick();
      bus.stop = 1'b0;
    end

    // reset during the first strobe of a basic frame
    pulse_start(7'b0000101, 16'd2, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) begin
        check("rst_c4_shift", 32'(bus.shift_en), 32'h01);
        reset = 1'b1;
      end
      if (c == 5) check("rst_c5_all", 32'({bus.shift_en, bus.cur_chan, bus.sample_cnt, bus.busy, bus.full}), 32'd0);
      tick();
      reset = 1'b0;
    end
    run_basic("again");

    // stop in DONE
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("done_stop", 32'({bus.full, bus.busy, bus.sample_cnt}), 32'({2'b00, 4'd10}));
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
